multicycle_controller: RTL and testbench

//  Multi-cycle RV32I control FSM. Sequences the shared-memory, single-ALU

---
 rtl/mc_ctrl_pkg.sv | 80 ++++++++
 rtl/mc_alu_decoder.sv | 37 +++
 rtl/multicycle_controller.sv | 207 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I controller: FSM state encoding,
// opcode constants, ALU function codes, immediate-format codes and datapath
// mux select codes. Also holds the opcode -> immediate-format decode.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_MEM_ADR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JAL,
        S_JALR_ADR,
        S_JALR_PC,
        S_LUI
    } state_t;

    // Coarse ALU request from the FSM; FUNCT defers to the instruction fields.
    typedef enum logic [1:0] {
        ALU_OP_ADD,
        ALU_OP_SUB,
        ALU_OP_FUNCT
    } alu_op_t;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_I    = 7'b0010011;
    localparam logic [6:0] OPC_LW   = 7'b0000011;
    localparam logic [6:0] OPC_SW   = 7'b0100011;
    localparam logic [6:0] OPC_BR   = 7'b1100011;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;
    localparam logic [6:0] OPC_LUI  = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLD_PC = 2'b01;
    localparam logic [1:0] SRCA_REG    = 2'b10;
    localparam logic [1:0] SRCA_ZERO   = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Immediate format depends only on the opcode; I-format covers I-ALU, lw, jalr.
    function automatic logic [2:0] imm_src_decode(input logic [6:0] opc);
        logic [2:0] sel;
        sel = IMM_I;
        case (opc)
            OPC_SW:  sel = IMM_S;
            OPC_BR:  sel = IMM_B;
            OPC_JAL: sel = IMM_J;
            OPC_LUI: sel = IMM_U;
            default: sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU function decoder: maps the FSM's coarse ALU request plus
// the instruction's opc/f3/f7 fields onto the 3-bit ALU function code.
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [6:0] opc,
    input  logic [2:0] f3,
    input  logic [6:0] f7,
    output logic [2:0] alu_func
);

    // Only f7[5] selects between add and sub; the remaining bits are ignored.
    logic unused_f7;
    assign unused_f7 = ^{f7[6], f7[4:0]};

    // Forced add/sub for address and compare micro-steps, otherwise f3-driven.
    always_comb begin
        alu_func = ALU_ADD;
        case (alu_op)
            ALU_OP_ADD: alu_func = ALU_ADD;
            ALU_OP_SUB: alu_func = ALU_SUB;
            default: begin
                case (f3)
                    3'b000:  alu_func = ((opc == OPC_R) && f7[5]) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_func = ALU_SLT;
                    3'b011:  alu_func = ALU_SLTU;
                    3'b100:  alu_func = ALU_XOR;
                    3'b110:  alu_func = ALU_OR;
                    3'b111:  alu_func = ALU_AND;
                    default: alu_func = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: one datapath micro-step per clock, driving
// register enables, mux selects and the ALU function.
// Optional feature: define CTRL_INSTR_CNT_EN to add the instr_count port and
// its retired-instruction counter.
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opc,
    input  logic [2:0]       f3,
    input  logic [6:0]       f7,
    input  logic             zero,
    input  logic             neg,
    output logic             PC_write,
    output logic             adr_src,
    output logic             mem_write,
    output logic             IR_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       ALU_src_A,
    output logic [1:0]       ALU_src_B,
    output logic [2:0]       imm_src,
    output logic [2:0]       ALU_func
`ifdef CTRL_INSTR_CNT_EN
    ,
    output logic [CNT_W-1:0] instr_count
`endif
);

    state_t  state;
    state_t  next_state;
    alu_op_t alu_op;
    logic    pc_write_d;
    logic    mem_write_d;
    logic    ir_write_d;
    logic    reg_write_d;
    logic    branch_taken;

    // State register; reset returns to FETCH and aborts any instruction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Branch condition from the compare result of A - B.
    always_comb begin
        branch_taken = 1'b0;
        case (f3)
            3'b000:  branch_taken = zero;
            3'b001:  branch_taken = ~zero;
            3'b100:  branch_taken = neg;
            3'b101:  branch_taken = ~neg;
            default: branch_taken = 1'b0;
        endcase
    end

    // Next-state and Moore output decode; PC_write in BRANCH is the only Mealy term.
    always_comb begin
        next_state  = state;
        pc_write_d  = 1'b0;
        adr_src     = 1'b0;
        mem_write_d = 1'b0;
        ir_write_d  = 1'b0;
        reg_write_d = 1'b0;
        result_src  = RES_ALUOUT;
        ALU_src_A   = SRCA_PC;
        ALU_src_B   = SRCB_REG;
        alu_op      = ALU_OP_ADD;
        case (state)
            S_FETCH: begin
                ir_write_d = 1'b1;
                pc_write_d = 1'b1;
                ALU_src_A  = SRCA_PC;
                ALU_src_B  = SRCB_FOUR;
                result_src = RES_ALU;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                ALU_src_A = SRCA_OLD_PC;
                ALU_src_B = SRCB_IMM;
                case (opc)
                    OPC_R:          next_state = S_EXEC_R;
                    OPC_I:          next_state = S_EXEC_I;
                    OPC_LW, OPC_SW: next_state = S_MEM_ADR;
                    OPC_BR:         next_state = S_BRANCH;
                    OPC_JAL:        next_state = S_JAL;
                    OPC_JALR:       next_state = S_JALR_ADR;
                    OPC_LUI:        next_state = S_LUI;
                    default:        next_state = S_FETCH;
                endcase
            end
            S_EXEC_R: begin
                ALU_src_A  = SRCA_REG;
                ALU_src_B  = SRCB_REG;
                alu_op     = ALU_OP_FUNCT;
                next_state = S_ALU_WB;
            end
            S_EXEC_I: begin
                ALU_src_A  = SRCA_REG;
                ALU_src_B  = SRCB_IMM;
                alu_op     = ALU_OP_FUNCT;
                next_state = S_ALU_WB;
            end
            S_ALU_WB: begin
                result_src  = RES_ALUOUT;
                reg_write_d = 1'b1;
                next_state  = S_FETCH;
            end
            S_MEM_ADR: begin
                ALU_src_A  = SRCA_REG;
                ALU_src_B  = SRCB_IMM;
                next_state = (opc == OPC_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                adr_src    = 1'b1;
                result_src = RES_ALUOUT;
                next_state = S_MEM_WB;
            end
            S_MEM_WB: begin
                result_src  = RES_DATA;
                reg_write_d = 1'b1;
                next_state  = S_FETCH;
            end
            S_MEM_WR: begin
                adr_src     = 1'b1;
                result_src  = RES_ALUOUT;
                mem_write_d = 1'b1;
                next_state  = S_FETCH;
            end
            S_BRANCH: begin
                ALU_src_A  = SRCA_REG;
                ALU_src_B  = SRCB_REG;
                alu_op     = ALU_OP_SUB;
                result_src = RES_ALUOUT;
                pc_write_d = branch_taken;
                next_state = S_FETCH;
            end
            S_JAL: begin
                ALU_src_A  = SRCA_OLD_PC;
                ALU_src_B  = SRCB_FOUR;
                result_src = RES_ALUOUT;
                pc_write_d = 1'b1;
                next_state = S_ALU_WB;
            end
            S_JALR_ADR: begin
                ALU_src_A  = SRCA_REG;
                ALU_src_B  = SRCB_IMM;
                next_state = S_JALR_PC;
            end
            S_JALR_PC: begin
                // PC takes the jump target in ALUOut while the ALU forms old PC + 4 for the link.
                result_src = RES_ALUOUT;
                pc_write_d = 1'b1;
                ALU_src_A  = SRCA_OLD_PC;
                ALU_src_B  = SRCB_FOUR;
                next_state = S_ALU_WB;
            end
            S_LUI: begin
                ALU_src_A  = SRCA_ZERO;
                ALU_src_B  = SRCB_IMM;
                next_state = S_ALU_WB;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase
    end

    // Write enables are held off for the whole reset pulse, including the asynchronous entry.
    assign PC_write  = pc_write_d  & ~rst;
    assign mem_write = mem_write_d & ~rst;
    assign IR_write  = ir_write_d  & ~rst;
    assign reg_write = reg_write_d & ~rst;

    assign imm_src = imm_src_decode(opc);

    mc_alu_decoder u_alu_decoder (
        .alu_op   (alu_op),
        .opc      (opc),
        .f3       (f3),
        .f7       (f7),
        .alu_func (ALU_func)
    );

`ifdef CTRL_INSTR_CNT_EN
    logic retire;
    assign retire = (state != S_FETCH) && (state != S_DECODE) && (next_state == S_FETCH);

    // Count instructions that complete; an illegal opcode returning from DECODE does not count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_count <= '0;
        end else if (retire) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end
`else
    localparam int unsigned UNUSED_CNT_W = CNT_W;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Each instruction is checked
// cycle by cycle against a table model built from per-instruction-class
// micro-step descriptions; instruction length comes from the class latency.
module tb_multicycle_controller;

    localparam int CW = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opc = '0;
    logic [2:0] f3  = '0;
    logic [6:0] f7  = '0;
    logic       zero = 1'b0;
    logic       neg  = 1'b0;
    logic       PC_write, adr_src, mem_write, IR_write, reg_write;
    logic [1:0] result_src, ALU_src_A, ALU_src_B;
    logic [2:0] imm_src, ALU_func;
`ifdef CTRL_INSTR_CNT_EN
    logic [CW-1:0] instr_count;
    logic [CW-1:0] exp_cnt = '0;
`endif

    int total = 0;
    int bad   = 0;

    logic [16:0] obs;
    logic [16:0] ov [8];
    logic        zv [8];
    logic        nv [8];

    assign obs = {PC_write, adr_src, mem_write, IR_write, reg_write,
                  result_src, ALU_src_A, ALU_src_B, imm_src, ALU_func};

    multicycle_controller #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .opc        (opc),
        .f3         (f3),
        .f7         (f7),
        .zero       (zero),
        .neg        (neg),
        .PC_write   (PC_write),
        .adr_src    (adr_src),
        .mem_write  (mem_write),
        .IR_write   (IR_write),
        .reg_write  (reg_write),
        .result_src (result_src),
        .ALU_src_A  (ALU_src_A),
        .ALU_src_B  (ALU_src_B),
        .imm_src    (imm_src),
        .ALU_func   (ALU_func)
`ifdef CTRL_INSTR_CNT_EN
        ,
        .instr_count(instr_count)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int lat(input logic [6:0] o);
        case (o)
            7'b1100011:                                     return 3;
            7'b0110011, 7'b0010011, 7'b0100011,
            7'b1101111, 7'b0110111:                         return 4;
            7'b0000011, 7'b1100111:                         return 5;
            default:                                        return 2;
        endcase
    endfunction

    function automatic logic [2:0] ref_imm(input logic [6:0] o);
        if (o == 7'b0100011) return 3'd1;
        if (o == 7'b1100011) return 3'd2;
        if (o == 7'b1101111) return 3'd3;
        if (o == 7'b0110111) return 3'd4;
        return 3'd0;
    endfunction

    function automatic logic [2:0] ref_func(input logic [6:0] o, input logic [2:0] a3, input logic [6:0] a7);
        case (a3)
            3'd0: return (o == 7'b0110011 && a7[5]) ? 3'd1 : 3'd0;
            3'd2: return 3'd5;
            3'd3: return 3'd6;
            3'd4: return 3'd4;
            3'd6: return 3'd3;
            3'd7: return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    // Expected outputs and compare mask for cycle c of an instruction (c=0 is fetch).
    // in_rst selects the values required while reset is asserted.
    function automatic void model(input logic [6:0] o, input logic [2:0] a3, input logic [6:0] a7,
                                  input logic z, input logic n, input int c, input bit in_rst,
                                  output logic [16:0] e, output logic [16:0] m);
        logic pcw, adr, mw, irw, rw;
        logic [1:0] rs, sa, sb;
        logic [2:0] fn;
        logic madr, mrs, msa, msb, mfn;
        logic tk;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0;
        rs = 0; sa = 0; sb = 0; fn = 0;
        madr = 0; mrs = 0; msa = 0; msb = 0; mfn = 0;
        case (a3)
            3'd0: tk = z;
            3'd1: tk = !z;
            3'd4: tk = n;
            3'd5: tk = !n;
            default: tk = 0;
        endcase
        if (in_rst || c == 0) begin
            pcw = !in_rst; irw = !in_rst; rs = 2'b10; sa = 2'b00; sb = 2'b10; fn = 3'd0;
            madr = 1; mrs = 1; msa = 1; msb = 1; mfn = 1;
        end else if (c == 1) begin
            sa = 2'b01; sb = 2'b01; fn = 3'd0; msa = 1; msb = 1; mfn = 1;
        end else if (c == lat(o) - 1 && o inside {7'b0110011, 7'b0010011, 7'b1101111,
                                                  7'b1100111, 7'b0110111}) begin
            rs = 2'b00; rw = 1; mrs = 1;
        end else begin
            case (o)
                7'b0110011: begin sa = 2'b10; sb = 2'b00; fn = ref_func(o, a3, a7); end
                7'b0010011: begin sa = 2'b10; sb = 2'b01; fn = ref_func(o, a3, a7); end
                7'b0000011, 7'b0100011: begin
                    if (c == 2) begin sa = 2'b10; sb = 2'b01; fn = 0; end
                    else if (o == 7'b0100011) begin adr = 1; rs = 2'b00; mw = 1; madr = 1; mrs = 1; end
                    else if (c == 3) begin adr = 1; rs = 2'b00; madr = 1; mrs = 1; end
                    else begin rs = 2'b01; rw = 1; mrs = 1; end
                end
                7'b1100011: begin sa = 2'b10; sb = 2'b00; fn = 3'd1; rs = 2'b00; mrs = 1; pcw = tk; end
                7'b1101111: begin sa = 2'b01; sb = 2'b10; fn = 0; rs = 2'b00; mrs = 1; pcw = 1; end
                7'b1100111: begin
                    if (c == 2) begin sa = 2'b10; sb = 2'b01; fn = 0; end
                    else begin sa = 2'b01; sb = 2'b10; fn = 0; rs = 2'b00; mrs = 1; pcw = 1; end
                end
                default: begin sa = 2'b11; sb = 2'b01; fn = 0; end
            endcase
            if (c == 2 || (o == 7'b1100111 && c == 3)) begin msa = 1; msb = 1; mfn = 1; end
        end
        e = {pcw, adr, mw, irw, rw, rs, sa, sb, ref_imm(o), fn};
        m = {1'b1, madr, 1'b1, 1'b1, 1'b1, {2{mrs}}, {2{msa}}, {2{msb}}, 3'b111, {3{mfn}}};
    endfunction

    function automatic void rand_instr(output logic [6:0] o, output logic [2:0] a3, output logic [6:0] a7);
        logic [6:0] tbl [8];
        tbl = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
        a3 = 3'($urandom);
        a7 = 7'($urandom);
        if ($urandom_range(8, 0) == 8) begin
            o = 7'($urandom);
            while (lat(o) != 2) o = 7'($urandom);
        end else begin
            o = tbl[$urandom_range(7, 0)];
        end
    endfunction

    // Drives one instruction for its model latency and records the observed outputs.
    // zf/nf < 0 randomise the ALU flags each cycle.
    task automatic run(input logic [6:0] o, input logic [2:0] a3, input logic [6:0] a7,
                       input int zf, input int nf, output int n);
        opc = o; f3 = a3; f7 = a7;
        n = lat(o);
        for (int c = 0; c < n; c++) begin
            zero = (zf < 0) ? 1'($urandom) : 1'(zf);
            neg  = (nf < 0) ? 1'($urandom) : 1'(nf);
            #1;
            zv[c] = zero; nv[c] = neg; ov[c] = obs;
            @(negedge clk);
        end
`ifdef CTRL_INSTR_CNT_EN
        if (n != 2) exp_cnt = exp_cnt + 1'b1;
`endif
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [16:0] e, m;
        @(negedge clk);
        rst = 1'b1; opc = 7'b0100011;
        #1;
        model(opc, f3, f7, zero, neg, 0, 1'b1, e, m);
        total++;
        if ((obs & m) !== (e & m)) begin
            bad++; $display("FAIL reset_outputs got=%h exp=%h", obs & m, e & m);
        end
`ifdef CTRL_INSTR_CNT_EN
        exp_cnt = '0;
        total++;
        if (instr_count !== exp_cnt) begin
            bad++; $display("FAIL reset_count got=%0d exp=%0d", instr_count, exp_cnt);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_alu_ops();
        logic [16:0] e, m;
        logic [6:0] o, a7;
        logic [2:0] a3;
        int n;
        for (int k = 0; k < 15; k++) begin
            case (k)
                0: begin o = 7'b0110011; a3 = 3'd0; a7 = 7'b0000000; end
                1: begin o = 7'b0110011; a3 = 3'd0; a7 = 7'b0100000; end
                2: begin o = 7'b0010011; a3 = 3'd0; a7 = 7'b0100000; end
                default: begin
                    o = ($urandom_range(1, 0) == 1) ? 7'b0110011 : 7'b0010011;
                    a3 = 3'($urandom); a7 = 7'($urandom);
                end
            endcase
            run(o, a3, a7, -1, -1, n);
            for (int c = 0; c < n; c++) begin
                model(o, a3, a7, zv[c], nv[c], c, 1'b0, e, m);
                total++;
                if ((ov[c] & m) !== (e & m)) begin
                    bad++; $display("FAIL alu k=%0d cyc=%0d got=%h exp=%h", k, c, ov[c] & m, e & m);
                end
            end
        end
    endtask

    task automatic test_memory();
        logic [16:0] e, m;
        logic [6:0] o;
        int n, wr;
        for (int k = 0; k < 2; k++) begin
            o = (k == 0) ? 7'b0000011 : 7'b0100011;
            run(o, 3'b010, 7'($urandom), -1, -1, n);
            wr = 0;
            for (int c = 0; c < n; c++) begin
                model(o, 3'b010, f7, zv[c], nv[c], c, 1'b0, e, m);
                total++;
                if ((ov[c] & m) !== (e & m)) begin
                    bad++; $display("FAIL mem k=%0d cyc=%0d got=%h exp=%h", k, c, ov[c] & m, e & m);
                end
                wr += int'(ov[c][14]);
            end
            total++;
            if (wr !== k) begin
                bad++; $display("FAIL mem_write_cycles k=%0d got=%0d exp=%0d", k, wr, k);
            end
        end
    endtask

    task automatic test_branch();
        logic [16:0] e, m;
        logic [2:0] a3;
        int n, zf, nf;
        for (int k = 0; k < 18; k++) begin
            if (k == 0)      begin a3 = 3'b001; zf = 1;  nf = 0;  end
            else if (k == 1) begin a3 = 3'b100; zf = 0;  nf = 1;  end
            else             begin a3 = 3'($urandom); zf = -1; nf = -1; end
            run(7'b1100011, a3, 7'($urandom), zf, nf, n);
            for (int c = 0; c < n; c++) begin
                model(7'b1100011, a3, f7, zv[c], nv[c], c, 1'b0, e, m);
                total++;
                if ((ov[c] & m) !== (e & m)) begin
                    bad++; $display("FAIL branch k=%0d f3=%0d cyc=%0d got=%h exp=%h", k, a3, c, ov[c] & m, e & m);
                end
            end
        end
    endtask

    task automatic test_jumps();
        logic [16:0] e, m;
        logic [6:0] o;
        int n;
        for (int k = 0; k < 3; k++) begin
            o = (k == 0) ? 7'b1101111 : (k == 1) ? 7'b1100111 : 7'b0110111;
            run(o, 3'($urandom), 7'($urandom), -1, -1, n);
            for (int c = 0; c < n; c++) begin
                model(o, f3, f7, zv[c], nv[c], c, 1'b0, e, m);
                total++;
                if ((ov[c] & m) !== (e & m)) begin
                    bad++; $display("FAIL jump opc=%b cyc=%0d got=%h exp=%h", o, c, ov[c] & m, e & m);
                end
            end
        end
    endtask

    task automatic test_illegal();
        logic [16:0] e, m;
        logic [6:0] o;
        int n;
        for (int k = 0; k < 4; k++) begin
            o = 7'b1111111;
            if (k > 0) begin
                o = 7'($urandom);
                while (lat(o) != 2) o = 7'($urandom);
            end
            run(o, 3'($urandom), 7'($urandom), -1, -1, n);
            for (int c = 0; c < n; c++) begin
                model(o, f3, f7, zv[c], nv[c], c, 1'b0, e, m);
                total++;
                if ((ov[c] & m) !== (e & m)) begin
                    bad++; $display("FAIL illegal opc=%b cyc=%0d got=%h exp=%h", o, c, ov[c] & m, e & m);
                end
            end
        end
        // The next instruction must start with a fetch.
        #1;
        total++;
        if (IR_write !== 1'b1 || ALU_src_B !== 2'b10) begin
            bad++; $display("FAIL illegal_refetch got=%b%b exp=110", IR_write, ALU_src_B);
        end
    endtask

    task automatic test_reset_mid();
        logic [16:0] e, m;
        int n;
        opc = 7'b0100011; f3 = 3'b010;
        for (int c = 0; c < 3; c++) @(negedge clk);
        #1;
        total++;
        if (mem_write !== 1'b1) begin
            bad++; $display("FAIL pre_reset_mem_write got=%b exp=1", mem_write);
        end
        rst = 1'b1;
        #1;
        model(opc, f3, f7, zero, neg, 0, 1'b1, e, m);
        total++;
        if ((obs & m) !== (e & m)) begin
            bad++; $display("FAIL mid_reset_outputs got=%h exp=%h", obs & m, e & m);
        end
`ifdef CTRL_INSTR_CNT_EN
        exp_cnt = '0;
`endif
        @(negedge clk);
        rst = 1'b0;
        run(7'b0110011, 3'd0, 7'd0, -1, -1, n);
        for (int c = 0; c < n; c++) begin
            model(7'b0110011, 3'd0, 7'd0, zv[c], nv[c], c, 1'b0, e, m);
            total++;
            if ((ov[c] & m) !== (e & m)) begin
                bad++; $display("FAIL after_reset cyc=%0d got=%h exp=%h", c, ov[c] & m, e & m);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] e, m;
        logic [6:0] o, a7;
        logic [2:0] a3;
        int n;
        for (int k = 0; k < 60; k++) begin
            rand_instr(o, a3, a7);
            run(o, a3, a7, -1, -1, n);
            for (int c = 0; c < n; c++) begin
                model(o, a3, a7, zv[c], nv[c], c, 1'b0, e, m);
                total++;
                if ((ov[c] & m) !== (e & m)) begin
                    bad++; $display("FAIL b2b k=%0d opc=%b cyc=%0d got=%h exp=%h", k, o, c, ov[c] & m, e & m);
                end
            end
`ifdef CTRL_INSTR_CNT_EN
            #1;
            total++;
            if (instr_count !== exp_cnt) begin
                bad++; $display("FAIL b2b_count k=%0d got=%0d exp=%0d", k, instr_count, exp_cnt);
            end
`endif
        end
    endtask

`ifdef CTRL_INSTR_CNT_EN
    task automatic test_counter();
        int n;
        test_reset();
        run(7'b1111111, 3'd0, 7'd0, -1, -1, n);
        #1;
        total++;
        if (instr_count !== exp_cnt) begin
            bad++; $display("FAIL count_illegal got=%0d exp=%0d", instr_count, exp_cnt);
        end
        for (int k = 0; k < 17; k++) begin
            run(7'b0110011, 3'd0, 7'd0, -1, -1, n);
            #1;
            total++;
            if (instr_count !== exp_cnt) begin
                bad++; $display("FAIL count_wrap k=%0d got=%0d exp=%0d", k, instr_count, exp_cnt);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_alu_ops();
        test_memory();
        test_branch();
        test_jumps();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
`ifdef CTRL_INSTR_CNT_EN
        test_counter();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
